sram_arbiter: RTL and testbench

- Shares the single external SRAM port between up to NUM_REQ effect blocks (chorus, delay, reverb) in one audio sample period.
- Each requester issues one-word read or write transactions through a req/done handshake.
- The arbiter serialises transactions round-robin and drives the SRAM bus. It sits between the effect chain and the top-level SRAM pins.
- Effects no longer count their own SRAM wait cycles.

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/sram_arbiter_rr_picker.sv | 31 +++
 rtl/sram_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_sram_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM arbiter slice.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int   SRAM_ADDR_W    = 20;
  localparam int   SRAM_DATA_W    = 16;
  localparam logic SRAM_IDLE_WE_N = 1'b1;
  localparam int   CNT_W          = 3;

endpackage

// File: rtl/sram_arbiter_rr_picker.sv
// Combinational round-robin search: first set request at or above rr_ptr, wrapping.
// Zero latency; no backpressure (pure function of its inputs).
module rr_picker #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_rr_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    int j;
    j        = 0;
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = int'(i_rr_ptr) + i;
      if (j >= N) j = j - N;
      if (!o_any && i_req[j]) begin
        o_any       = 1'b1;
        o_onehot[j] = 1'b1;
        o_idx       = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port; IDLE -> ACCESS -> DONE per transaction.
// Optional SRAM_ARB_STATS_EN adds o_max_wait (longest request-to-grant wait, saturating).
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ      = 3,
  parameter int ADDR_W       = SRAM_ADDR_W,
  parameter int DATA_W       = SRAM_DATA_W,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ-1:0]        i_we_n,
  input  logic [NUM_REQ*ADDR_W-1:0] i_addr,
  input  logic [NUM_REQ*DATA_W-1:0] i_wdata,
  output logic [NUM_REQ-1:0]        o_gnt,
  output logic [NUM_REQ-1:0]        o_done,
  output logic [DATA_W-1:0]         o_rdata,
  output logic                      o_busy,
  output logic [ADDR_W-1:0]         o_sram_addr,
  output logic                      o_sram_we_n,
  output logic [DATA_W-1:0]         o_sram_wdata,
  input  logic [DATA_W-1:0]         i_sram_rdata
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [7:0]                o_max_wait
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               busy_q, busy_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_n_q, we_n_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               rd_q, rd_d;

  logic [NUM_REQ-1:0] win_oh;
  logic [IDX_W-1:0]   win_idx;
  logic               any_req;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_picker (
    .i_req    (i_req),
    .i_rr_ptr (rr_ptr_q),
    .o_onehot (win_oh),
    .o_idx    (win_idx),
    .o_any    (any_req)
  );

  // The SRAM bus flops double as the latched request fields during ACCESS.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    rdata_d  = rdata_q;
    busy_d   = busy_q;
    addr_d   = addr_q;
    we_n_d   = we_n_q;
    wdata_d  = wdata_q;
    rd_d     = rd_q;
    unique case (state_q)
      IDLE: begin
        addr_d  = '0;
        we_n_d  = SRAM_IDLE_WE_N;
        wdata_d = '0;
        gnt_d   = '0;
        busy_d  = 1'b0;
        if (any_req) begin
          state_d  = ACCESS;
          busy_d   = 1'b1;
          gnt_d    = win_oh;
          addr_d   = i_addr[int'(win_idx)*ADDR_W +: ADDR_W];
          wdata_d  = i_wdata[int'(win_idx)*DATA_W +: DATA_W];
          rd_d     = i_we_n[win_idx];
          we_n_d   = i_we_n[win_idx];
          cnt_d    = i_we_n[win_idx] ? CNT_W'(READ_CYCLES) : CNT_W'(WRITE_CYCLES);
          rr_ptr_d = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          addr_d  = '0;
          we_n_d  = SRAM_IDLE_WE_N;
          wdata_d = '0;
          done_d  = gnt_q;
          if (rd_q) rdata_d = i_sram_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      addr_q   <= '0;
      we_n_q   <= SRAM_IDLE_WE_N;
      wdata_q  <= '0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
      addr_q   <= addr_d;
      we_n_q   <= we_n_d;
      wdata_q  <= wdata_d;
      rd_q     <= rd_d;
    end
  end

  assign o_gnt        = gnt_q;
  assign o_done       = done_q;
  assign o_rdata      = rdata_q;
  assign o_busy       = busy_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_wdata = wdata_q;

`ifdef SRAM_ARB_STATS_EN
  logic [NUM_REQ-1:0][7:0] wait_q, wait_d;
  logic [7:0]              max_wait_q, max_wait_d;
  logic [NUM_REQ-1:0]      grant_now;

  assign grant_now = (state_q == IDLE) ? win_oh : '0;

  // A wait counts edges a request was seen high but not yet owning the bus.
  always_comb begin
    wait_d     = wait_q;
    max_wait_d = max_wait_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i_req[k] && !gnt_q[k] && !grant_now[k]) begin
        wait_d[k] = (wait_q[k] == 8'hFF) ? wait_q[k] : wait_q[k] + 8'd1;
      end else begin
        wait_d[k] = 8'd0;
      end
    end
    if (any_req && (state_q == IDLE) && (wait_q[win_idx] > max_wait_q)) begin
      max_wait_d = wait_q[win_idx];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wait_q     <= '0;
      max_wait_q <= '0;
    end else begin
      wait_q     <= wait_d;
      max_wait_q <= max_wait_d;
    end
  end

  assign o_max_wait = max_wait_q;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with an SRAM model and an o_done scoreboard.
module tb_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 20;
  localparam int DW = 16;

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [N-1:0]    i_req;
  logic [N-1:0]    i_we_n;
  logic [N*AW-1:0] i_addr;
  logic [N*DW-1:0] i_wdata;
  logic [N-1:0]    o_gnt;
  logic [N-1:0]    o_done;
  logic [DW-1:0]   o_rdata;
  logic            o_busy;
  logic [AW-1:0]   o_sram_addr;
  logic            o_sram_we_n;
  logic [DW-1:0]   o_sram_wdata;
  logic [DW-1:0]   i_sram_rdata;
`ifdef SRAM_ARB_STATS_EN
  logic [7:0]      o_max_wait;
`endif

  sram_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .READ_CYCLES(2), .WRITE_CYCLES(1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_we_n(i_we_n),
    .i_addr(i_addr), .i_wdata(i_wdata), .o_gnt(o_gnt), .o_done(o_done),
    .o_rdata(o_rdata), .o_busy(o_busy), .o_sram_addr(o_sram_addr),
    .o_sram_we_n(o_sram_we_n), .o_sram_wdata(o_sram_wdata),
    .i_sram_rdata(i_sram_rdata)
`ifdef SRAM_ARB_STATS_EN
    , .o_max_wait(o_max_wait)
`endif
  );

  always #5 i_clk = ~i_clk;

  // SRAM model: fixed preload contents, overlaid by anything written (low 8 address bits).
  logic          mem_clr;
  logic [255:0]  wvld;
  logic [DW-1:0] wmem [256];

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      20'h02328: rom = 16'hA5A5;
      20'h00010: rom = 16'h1111;
      20'h00020: rom = 16'h2222;
      20'h00030: rom = 16'h3333;
      20'h00040: rom = 16'h4444;
      20'h00050: rom = 16'h5555;
      default:   rom = 16'h0000;
    endcase
  endfunction

  always @(posedge i_clk) begin
    if (mem_clr) wvld <= '0;
    else if (!o_sram_we_n) begin
      wvld[o_sram_addr[7:0]] <= 1'b1;
      wmem[o_sram_addr[7:0]] <= o_sram_wdata;
    end
  end

  always_comb begin
    i_sram_rdata = rom(o_sram_addr);
    if (wvld[o_sram_addr[7:0]]) i_sram_rdata = wmem[o_sram_addr[7:0]];
  end

  typedef struct {
    logic [N-1:0]  oh;
    logic          rd;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [N-1:0] oh, input logic rd, input logic [DW-1:0] data);
    exp_t e;
    e.oh = oh; e.rd = rd; e.data = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every completion pulse must match the oldest expected completion.
  always @(negedge i_clk) begin
    if (i_rst_n && (o_done != '0)) begin
      if (sb_q.size() == 0) begin
        chk("done_unexpected", 32'(o_done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("done_owner", 32'(o_done), 32'(e.oh));
        chk("gnt_at_done", 32'(o_gnt), 32'(e.oh));
        if (e.rd) chk("rdata", 32'(o_rdata), 32'(e.data));
      end
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic we_n, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    i_we_n[k]          = we_n;
    i_addr[k*AW +: AW] = a;
    i_wdata[k*DW +: DW] = d;
    i_req[k]           = 1'b1;
  endtask

  // Requester behaviour: hold each request until its o_done is seen, drop on the next edge.
  task automatic service(input int budget);
    logic [N-1:0] d;
    int n;
    n = 0;
    while ((i_req != '0) && (n < budget)) begin
      tick; n++;
      if (o_done != '0) begin
        d = o_done;
        tick; n++;
        i_req = i_req & ~d;
      end
    end
    chk("service_timeout", 32'(i_req), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; mem_clr = 1'b1;
    i_req = '0; i_we_n = '1; i_addr = '0; i_wdata = '0;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_gnt", 32'(o_gnt), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_rdata", 32'(o_rdata), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_addr", 32'(o_sram_addr), 32'd0);
    chk("rst_we_n", 32'(o_sram_we_n), 32'd1);
    chk("rst_wdata", 32'(o_sram_wdata), 32'd0);
`ifdef SRAM_ARB_STATS_EN
    chk("rst_max_wait", 32'(o_max_wait), 32'd0);
`endif
    mem_clr = 1'b0; i_rst_n = 1'b1;
    tick;

    // Single write by requester 0.
    set_req(0, 1'b0, 20'h00123, 16'h7FFF);
    push(3'b001, 1'b0, 16'h0);
    tick;
    chk("wr_gnt", 32'(o_gnt), 32'h1);
    chk("wr_we_n", 32'(o_sram_we_n), 32'd0);
    chk("wr_addr", 32'(o_sram_addr), 32'h00123);
    chk("wr_wdata", 32'(o_sram_wdata), 32'h7FFF);
    chk("wr_busy", 32'(o_busy), 32'd1);
    tick;
    chk("wr_done_lat", 32'(o_done), 32'h1);
    chk("wr_done_we_n", 32'(o_sram_we_n), 32'd1);
    chk("wr_done_gnt", 32'(o_gnt), 32'h1);
    tick;
    i_req[0] = 1'b0;
    chk("wr_idle_gnt", 32'(o_gnt), 32'd0);
    chk("wr_idle_busy", 32'(o_busy), 32'd0);
    tick;

    // Single read by requester 1.
    set_req(1, 1'b1, 20'h02328, 16'h0);
    push(3'b010, 1'b1, 16'hA5A5);
    tick;
    chk("rd_gnt", 32'(o_gnt), 32'h2);
    chk("rd_addr1", 32'(o_sram_addr), 32'h02328);
    chk("rd_we_n", 32'(o_sram_we_n), 32'd1);
    tick;
    chk("rd_addr2", 32'(o_sram_addr), 32'h02328);
    chk("rd_no_done_early", 32'(o_done), 32'd0);
    tick;
    chk("rd_done_lat", 32'(o_done), 32'h2);
    tick;
    i_req[1] = 1'b0;
    tick;
    chk("rd_rdata_held", 32'(o_rdata), 32'hA5A5);

    // Requester 2 read; address changed and request dropped during ACCESS.
    set_req(2, 1'b1, 20'h00040, 16'h0);
    push(3'b100, 1'b1, 16'h4444);
    tick;
    chk("mid_addr1", 32'(o_sram_addr), 32'h00040);
    i_addr[2*AW +: AW] = 20'h00050;
    i_req[2] = 1'b0;
    tick;
    chk("mid_addr2", 32'(o_sram_addr), 32'h00040);
    tick;
    chk("mid_done", 32'(o_done), 32'h4);
    tick;
    tick;
    chk("mid_idle_busy", 32'(o_busy), 32'd0);

    // Three simultaneous reads with rr_ptr back at 0.
    set_req(0, 1'b1, 20'h00010, 16'h0);
    set_req(1, 1'b1, 20'h00020, 16'h0);
    set_req(2, 1'b1, 20'h00030, 16'h0);
    push(3'b001, 1'b1, 16'h1111);
    push(3'b010, 1'b1, 16'h2222);
    push(3'b100, 1'b1, 16'h3333);
    service(60);
`ifdef SRAM_ARB_STATS_EN
    chk("max_wait", 32'(o_max_wait), 32'd8);
`endif

    // Requesters 0 and 2 together: pointer wrapped to 0, so 0 first.
    set_req(0, 1'b1, 20'h00123, 16'h0);
    set_req(2, 1'b1, 20'h02328, 16'h0);
    push(3'b001, 1'b1, 16'h7FFF);
    push(3'b100, 1'b1, 16'hA5A5);
    service(40);
    tick;

    // Reset in the middle of a write by requester 1.
    set_req(1, 1'b0, 20'h00060, 16'hBEEF);
    tick;
    chk("rstw_we_n_low", 32'(o_sram_we_n), 32'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("rstw_we_n_async", 32'(o_sram_we_n), 32'd1);
    chk("rstw_gnt", 32'(o_gnt), 32'd0);
    chk("rstw_busy", 32'(o_busy), 32'd0);
    i_req = '0;
    repeat (2) tick;
    i_rst_n = 1'b1;
    tick;
    chk("rstw_no_done", 32'(o_done), 32'd0);

    // After reset rr_ptr is 0: requester 0 beats requester 2.
    set_req(0, 1'b1, 20'h00010, 16'h0);
    set_req(2, 1'b1, 20'h00020, 16'h0);
    push(3'b001, 1'b1, 16'h1111);
    push(3'b100, 1'b1, 16'h2222);
    tick;
    chk("rstw_ptr_gnt", 32'(o_gnt), 32'h1);
    service(40);
    repeat (3) tick;
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
